// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: shifts WIDTH-bit words out on a one bit per cycle,
// with a one-word pending buffer so back-to-back words stream without gaps.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0,
    parameter int WCNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic              a,
    output logic              a_valid,
    output logic              a_last,
    output logic [WCNT_W-1:0] word_cnt
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(WIDTH - 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = {WCNT_W{1'b1}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   sr_r, sr_s;
    logic [WIDTH-1:0]   pend_r, pend_s;
    logic               pend_full_r, pend_full_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [WCNT_W-1:0]  word_cnt_r, word_cnt_s;
    logic               accept_s;
    logic               last_s;

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return {v[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, v[WIDTH-1:1]};
        end
    endfunction

    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return v[WIDTH-1];
        end else begin
            return v[0];
        end
    endfunction

    // Handshake and stream outputs decode registered state only.
    assign in_ready = ~pend_full_r;
    assign accept_s = in_valid & ~pend_full_r;
    assign a_valid  = (state_r == SHIFT);
    assign last_s   = (state_r == SHIFT) && (cnt_r == CNT_MAX);
    assign a_last   = last_s;
    assign a        = (state_r == SHIFT) ? out_bit(sr_r) : IDLE_BIT;
    assign word_cnt = word_cnt_r;

    // Next-state: load, shift, pending-buffer reload/bypass and saturating word count.
    always_comb begin
        state_s     = state_r;
        sr_s        = sr_r;
        cnt_s       = cnt_r;
        pend_s      = pend_r;
        pend_full_s = pend_full_r;
        word_cnt_s  = word_cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    sr_s    = in_data;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    if (word_cnt_r != WCNT_MAX) begin
                        word_cnt_s = word_cnt_r + WCNT_W'(1);
                    end else begin
                        word_cnt_s = word_cnt_r;
                    end
                    // Pending word wins; in_ready is low then, so no accept can collide.
                    if (pend_full_r) begin
                        sr_s        = pend_r;
                        pend_full_s = 1'b0;
                        cnt_s       = {CNT_W{1'b0}};
                    end else if (accept_s) begin
                        sr_s  = in_data;
                        cnt_s = {CNT_W{1'b0}};
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    sr_s  = shift_once(sr_r);
                    cnt_s = cnt_r + CNT_W'(1);
                    if (accept_s) begin
                        pend_s      = in_data;
                        pend_full_s = 1'b1;
                    end else begin
                        pend_full_s = pend_full_r;
                    end
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            sr_r        <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            pend_r      <= {WIDTH{1'b0}};
            pend_full_r <= 1'b0;
            word_cnt_r  <= {WCNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            sr_r        <= sr_s;
            cnt_r       <= cnt_s;
            pend_r      <= pend_s;
            pend_full_r <= pend_full_s;
            word_cnt_r  <= word_cnt_s;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: three instances (default, LSB-first with idle-high,
// 4-bit word counter) share clock and reset; expected bits are queued on each accept.
module tb_bit_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  v;
    logic [2:0]  rdy;
    logic [2:0]  a;
    logic [2:0]  av;
    logic [2:0]  al;
    logic [7:0]  dat [3];
    logic [15:0] wc0;
    logic [15:0] wc1;
    logic [3:0]  wc2;
    int          total = 0;
    int          bad   = 0;
    logic [1:0]  q0[$];
    logic [1:0]  q1[$];
    logic [1:0]  q2[$];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .WCNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .in_valid(v[0]), .in_data(dat[0]), .in_ready(rdy[0]),
        .a(a[0]), .a_valid(av[0]), .a_last(al[0]), .word_cnt(wc0));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1), .WCNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .in_valid(v[1]), .in_data(dat[1]), .in_ready(rdy[1]),
        .a(a[1]), .a_valid(av[1]), .a_last(al[1]), .word_cnt(wc1));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .WCNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .in_valid(v[2]), .in_data(dat[2]), .in_ready(rdy[2]),
        .a(a[2]), .a_valid(av[2]), .a_last(al[2]), .word_cnt(wc2));

    function automatic logic idle_lvl(input int d);
        return (d == 1);
    endfunction

    function automatic int qsize(input int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] qpop(input int d);
        case (d)
            0: return q0.pop_front();
            1: return q1.pop_front();
            2: return q2.pop_front();
            default: return 2'b00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected {bit, last} pairs for one accepted word, in shift order.
    task automatic push(input int d, input logic [7:0] w);
        logic [1:0] e;
        for (int i = 0; i < 8; i++) begin
            e = {((d != 1) ? w[7-i] : w[i]), (i == 7)};
            case (d)
                0: q0.push_back(e);
                1: q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    task automatic mon(input int d);
        logic [1:0] e;
        check($sformatf("dut%0d_a_valid", d), 32'(av[d]), 32'(qsize(d) != 0));
        if (av[d] === 1'b1 && qsize(d) != 0) begin
            e = qpop(d);
            check($sformatf("dut%0d_bit_last", d), 32'({a[d], al[d]}), 32'(e));
        end else if (av[d] === 1'b0) begin
            check($sformatf("dut%0d_idle_level", d), 32'(a[d]), 32'(idle_lvl(d)));
        end
    endtask

    // Stream monitor: every cycle out of reset, compare against the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            for (int d = 0; d < 3; d++) begin
                mon(d);
            end
        end
    end

    task automatic send(input int d, input logic [7:0] w);
        int n;
        n = 0;
        v[d]   = 1'b1;
        dat[d] = w;
        @(negedge clk);
        while (rdy[d] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("dut%0d_send_ready", d), 32'(rdy[d]), 32'd1);
        @(posedge clk);
        #1;
        if (n < 100) begin
            push(d, w);
        end else begin
            v[d] = 1'b0;
        end
    endtask

    task automatic idle(input int d);
        v[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (qsize(d) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("dut%0d_drain", d), 32'(qsize(d)), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s_a_valid%0d", tag, d), 32'(av[d]), 32'd0);
            check($sformatf("%s_a_last%0d", tag, d), 32'(al[d]), 32'd0);
            check($sformatf("%s_a%0d", tag, d), 32'(a[d]), 32'(idle_lvl(d)));
            check($sformatf("%s_ready%0d", tag, d), 32'(rdy[d]), 32'd1);
        end
        check({tag, "_wc0"}, 32'(wc0), 32'd0);
        check({tag, "_wc1"}, 32'(wc1), 32'd0);
        check({tag, "_wc2"}, 32'(wc2), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        v     = 3'b000;
        for (int d = 0; d < 3; d++) begin
            dat[d] = 8'h00;
        end
        #2;
        check_reset_outputs("in_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_outputs("after_reset");

        // Single word, MSB first.
        send(0, 8'b0110_0100);
        idle(0);
        drain(0);
        check("single_wc", 32'(wc0), 32'd1);
        check("single_idle_a", 32'(a[0]), 32'd0);
        check("single_idle_valid", 32'(av[0]), 32'd0);

        // Back-to-back via pending buffer.
        send(0, 8'hA5);
        send(0, 8'h3C);
        idle(0);
        drain(0);
        check("b2b_wc", 32'(wc0), 32'd3);

        // Second word accepted exactly on the final-bit edge (direct reload).
        send(0, 8'h5A);
        idle(0);
        repeat (7) @(posedge clk);
        #1;
        send(0, 8'hC3);
        idle(0);
        drain(0);
        check("bypass_wc", 32'(wc0), 32'd5);

        // Backpressure: third word held while the pending buffer is full.
        send(0, 8'h11);
        send(0, 8'h22);
        dat[0] = 8'h33;
        check("bp_ready_low", 32'(rdy[0]), 32'd0);
        send(0, 8'h33);
        idle(0);
        drain(0);
        check("bp_wc", 32'(wc0), 32'd8);
        check("bp_ready_back", 32'(rdy[0]), 32'd1);

        // LSB-first instance with idle-high line.
        send(1, 8'h01);
        send(1, 8'h80);
        idle(1);
        drain(1);
        check("lsb_wc", 32'(wc1), 32'd2);
        check("lsb_idle_a", 32'(a[1]), 32'd1);

        // Counter saturation with a 4-bit word counter.
        for (int k = 0; k < 17; k++) begin
            send(2, 8'(k * 7 + 3));
        end
        idle(2);
        drain(2);
        check("sat_wc17", 32'(wc2), 32'd15);
        send(2, 8'hFF);
        idle(2);
        drain(2);
        check("sat_wc_hold", 32'(wc2), 32'd15);

        // Reset mid-word with a pending word.
        send(0, 8'hF0);
        send(0, 8'h0F);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_pend_full", 32'(rdy[0]), 32'd0);
        v[0]  = 1'b0;
        reset = 1'b1;
        q0.delete();
        q1.delete();
        q2.delete();
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_outputs("mid_after");
        send(0, 8'h96);
        idle(0);
        drain(0);
        check("post_reset_wc", 32'(wc0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8: bits per parallel word, range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 shifts bit WIDTH-1 out first, 0 shifts bit 0 out first.
REQ-003 Parameter IDLE_BIT, default 0: level driven on a while no word is shifting.
REQ-004 Parameter WCNT_W, default 16: width of the completed-word counter.
REQ-005 One clock and an asynchronous, active-high reset: ports clk and reset, as below.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 in_valid  input  1  in_data holds a word offered for serialisation.
REQ-009 in_data  input  WIDTH  parallel word.
REQ-010 in_ready  output  1  block can accept a word this cycle.
REQ-011 a  output  1  serial bit stream, feeding the sequence-detector a input.
REQ-012 a_valid  output  1  a carries a data bit this cycle.
REQ-013 a_last  output  1  a carries the final bit of a word this cycle.
REQ-014 word_cnt  output  WCNT_W  number of fully shifted words, saturating.

Function
REQ-015 Internal state: FSM {IDLE, SHIFT}, shift register sr[WIDTH], bit index cnt (0..WIDTH-1), one-word pending buffer pend with flag pend_full.
REQ-016 A word is accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-017 in_ready = ~pend_full, decoded from registered state only, with no combinational path from in_valid.
REQ-018 IDLE + accept: load sr from in_data, set cnt=0, enter SHIFT; the first bit appears on a in the cycle after the accept edge (latency 1).
REQ-019 a_valid=1 exactly when state=SHIFT; a = sr next-out bit in SHIFT, else IDLE_BIT.
REQ-020 SHIFT, each edge with cnt<WIDTH-1: shift sr one position in the MSB_FIRST direction and increment cnt.
REQ-021 a_last=1 exactly when state=SHIFT and cnt=WIDTH-1.
REQ-022 At the edge ending a_last, priority is as follows. First, if pend_full, load sr from pend and clear pend_full. Otherwise, if a word is accepted, load sr directly from in_data. Otherwise, enter IDLE.
REQ-023 When the REQ-022 edge reloads sr, set cnt=0 and stay in SHIFT, so back-to-back words give continuous a_valid with no gap cycle.
REQ-024 SHIFT + accept on any edge not covered by the bypass case of REQ-022: write pend and set pend_full.
REQ-025 pend_full=1 forces in_ready=0; an offered word is held upstream, never dropped and never overwritten.
REQ-026 word_cnt increments by 1 at each edge ending a_last and holds at 2^WCNT_W-1; it never wraps.
REQ-027 in_data is sampled only on the accept edge; later changes do not affect the word in flight.
REQ-028 Shift latency is WIDTH cycles per word; sustained throughput is 1 bit/cycle while words are supplied.

Reset
REQ-029 reset=1 asynchronously forces state=IDLE, sr=0, cnt=0, pend=0, pend_full=0 and word_cnt=0.
REQ-030 Outputs during and immediately after reset: a=IDLE_BIT, a_valid=0, a_last=0, in_ready=1, word_cnt=0.
REQ-031 Reset asserted mid-word aborts the word and discards pend; no partial-word count is recorded.
REQ-032 No accept occurs while reset=1; normal operation resumes on the first rising edge after deassertion.

Verification
REQ-033 Single word, default parameters: accept 8'b0110_0100 -> a = 0,1,1,0,0,1,0,0 on the 8 following cycles, a_last on the 8th only, then IDLE with a=0 and word_cnt=1.
REQ-034 Back-to-back: offer 8'hA5 then 8'h3C with in_valid held -> 16 consecutive a_valid cycles, bits 10100101 00111100, a_last on cycles 8 and 16, word_cnt=2.
REQ-035 Backpressure: offer 3 words continuously -> in_ready=0 while pend_full; word 3 is held and stream order 1,2,3 is preserved with no loss; word_cnt=3.
REQ-036 MSB_FIRST=0, accept 8'h01 -> a = 1,0,0,0,0,0,0,0.
REQ-037 Reset after the 3rd bit of a word with pend_full=1 -> next cycle a_valid=0, in_ready=1, word_cnt=0; a new word then shifts correctly from bit 0.
REQ-038 WCNT_W=4: stream 17 words -> word_cnt reaches 15 and holds at 15.
